ps2_keyboard: RTL and testbench

PS/2 keyboard receiver that drives the computer's 16-bit keyboard input (`kb_in`) with the code of the currently held key, or 0 when no key is held. It deserialises PS/2 frames from a keyboard and tracks make, break and extended prefixes. It translates scan-code set 2 into the 16-bit key codes the data memory maps into its keyboard register.

---
 rtl/ps2_keyboard_if.sv | 17 +
 rtl/ps2_keyboard.sv | 168 ++++++++++++++++
 tb/tb_ps2_keyboard.sv | 177 +++++++++++++++++
 3 files changed

// File: rtl/ps2_keyboard_if.sv
// ps2_keyboard_if: groups the PS/2 pins and the keyboard-register outputs
// of the ps2_keyboard receiver.
//   ps2_clk, ps2_data : PS/2 clock and data pins (asynchronous to clk)
//   kb_out            : 16-bit code of the held key, 0 when none
//   key_event         : one-cycle pulse when kb_out changes
//   frame_err         : one-cycle pulse on parity, stop-bit or timeout error
// Modports: slave = receiver side, master = keyboard/host side.
interface ps2_keyboard_if;
  logic        ps2_clk;
  logic        ps2_data;
  logic [15:0] kb_out;
  logic        key_event;
  logic        frame_err;

  modport master (output ps2_clk, ps2_data, input kb_out, key_event, frame_err);
  modport slave  (input ps2_clk, ps2_data, output kb_out, key_event, frame_err);
endinterface

// File: rtl/ps2_keyboard.sv
// ps2_keyboard: PS/2 keyboard receiver. Deserialises 11-bit PS/2 frames,
// tracks E0 (extended) and F0 (break) prefixes and translates scan-code
// set 2 into the 16-bit key code of the currently held key.
// Ports:
//   clk      : system clock (at least 8x the PS/2 clock rate)
//   reset    : asynchronous active-low reset
//   bus      : ps2_keyboard_if.slave (ps2_clk, ps2_data in; kb_out,
//              key_event, frame_err out)
// Parameter TIMEOUT_CYCLES: mid-frame idle limit in clk cycles.
// Optional macro PS2_TIMEOUT_EN: builds the mid-frame timeout counter;
// without it the FSM waits indefinitely and TIMEOUT_CYCLES is unused.
module ps2_keyboard #(
  parameter int TIMEOUT_CYCLES = 50000
) (
  input logic         clk,
  input logic         reset,
  ps2_keyboard_if.slave bus
);

  typedef enum logic [1:0] {S_IDLE, S_DATA, S_PARITY, S_STOP} state_t;

  state_t      r_state, w_state_next;
  logic        r_clk_s1, r_clk_s2, r_clk_prev;
  logic        r_dat_s1, r_dat_s2;
  logic [7:0]  r_shift;
  logic [2:0]  r_bit_cnt;
  logic        r_par_ok;
  logic        r_ext, r_brk;
  logic [8:0]  r_held;
  logic [15:0] r_kb_out;
  logic        r_key_event, r_frame_err;

  logic        w_fall, w_data;
  logic        w_byte_valid, w_err, w_timeout;
  logic [15:0] w_map;

  assign w_fall = r_clk_prev & ~r_clk_s2;
  assign w_data = r_dat_s2;

  // Scan-code set 2 to key code; 0 means unmapped (no valid code is 0).
  function automatic logic [15:0] f_map(input logic ext, input logic [7:0] code);
    case ({ext, code})
      9'h01C: f_map = 16'd65;  9'h032: f_map = 16'd66;  9'h021: f_map = 16'd67;
      9'h023: f_map = 16'd68;  9'h024: f_map = 16'd69;  9'h02B: f_map = 16'd70;
      9'h034: f_map = 16'd71;  9'h033: f_map = 16'd72;  9'h043: f_map = 16'd73;
      9'h03B: f_map = 16'd74;  9'h042: f_map = 16'd75;  9'h04B: f_map = 16'd76;
      9'h03A: f_map = 16'd77;  9'h031: f_map = 16'd78;  9'h044: f_map = 16'd79;
      9'h04D: f_map = 16'd80;  9'h015: f_map = 16'd81;  9'h02D: f_map = 16'd82;
      9'h01B: f_map = 16'd83;  9'h02C: f_map = 16'd84;  9'h03C: f_map = 16'd85;
      9'h02A: f_map = 16'd86;  9'h01D: f_map = 16'd87;  9'h022: f_map = 16'd88;
      9'h035: f_map = 16'd89;  9'h01A: f_map = 16'd90;
      9'h045: f_map = 16'd48;  9'h016: f_map = 16'd49;  9'h01E: f_map = 16'd50;
      9'h026: f_map = 16'd51;  9'h025: f_map = 16'd52;  9'h02E: f_map = 16'd53;
      9'h036: f_map = 16'd54;  9'h03D: f_map = 16'd55;  9'h03E: f_map = 16'd56;
      9'h046: f_map = 16'd57;
      9'h029: f_map = 16'd32;  9'h05A: f_map = 16'd128; 9'h066: f_map = 16'd129;
      9'h076: f_map = 16'd140;
      9'h16B: f_map = 16'd130; 9'h175: f_map = 16'd131; 9'h174: f_map = 16'd132;
      9'h172: f_map = 16'd133;
      default: f_map = 16'd0;
    endcase
  endfunction

  assign w_map = f_map(r_ext, r_shift);

`ifdef PS2_TIMEOUT_EN
  localparam int CW = $clog2(TIMEOUT_CYCLES + 1);
  logic [CW-1:0] r_to_cnt;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset)                          r_to_cnt <= '0;
    else if (w_fall || r_state == S_IDLE) r_to_cnt <= '0;
    else                                 r_to_cnt <= r_to_cnt + 1'b1;
  end

  // A falling edge in the terminal cycle restarts the count instead.
  assign w_timeout = (r_state != S_IDLE) && !w_fall &&
                     (r_to_cnt == CW'(TIMEOUT_CYCLES - 1));
`else
  logic w_unused_timeout;
  assign w_unused_timeout = (TIMEOUT_CYCLES != 0);
  assign w_timeout        = 1'b0;
`endif

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_clk_s1 <= 1'b1; r_clk_s2 <= 1'b1; r_clk_prev <= 1'b1;
      r_dat_s1 <= 1'b1; r_dat_s2 <= 1'b1;
      r_state  <= S_IDLE;
    end else begin
      r_clk_s1 <= bus.ps2_clk;  r_clk_s2 <= r_clk_s1; r_clk_prev <= r_clk_s2;
      r_dat_s1 <= bus.ps2_data; r_dat_s2 <= r_dat_s1;
      r_state  <= w_state_next;
    end
  end

  always_comb begin
    w_state_next = r_state;
    w_byte_valid = 1'b0;
    w_err        = 1'b0;
    if (w_timeout) begin
      w_state_next = S_IDLE;
      w_err        = 1'b1;
    end else if (w_fall) begin
      case (r_state)
        S_IDLE:   if (!w_data) w_state_next = S_DATA;  // data=1 is a glitch
        S_DATA:   if (r_bit_cnt == 3'd7) w_state_next = S_PARITY;
        S_PARITY: w_state_next = S_STOP;
        S_STOP: begin
          w_state_next = S_IDLE;
          if (w_data && r_par_ok) w_byte_valid = 1'b1;
          else                    w_err        = 1'b1;
        end
        default:  w_state_next = S_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_shift <= '0; r_bit_cnt <= '0; r_par_ok <= 1'b0;
      r_ext <= 1'b0; r_brk <= 1'b0; r_held <= '0;
      r_kb_out <= '0; r_key_event <= 1'b0; r_frame_err <= 1'b0;
    end else begin
      r_key_event <= 1'b0;
      r_frame_err <= 1'b0;
      if (w_fall) begin
        case (r_state)
          S_IDLE:   r_bit_cnt <= '0;
          S_DATA: begin
            r_shift   <= {w_data, r_shift[7:1]};
            r_bit_cnt <= r_bit_cnt + 3'd1;
          end
          S_PARITY: r_par_ok <= ^{r_shift, w_data};  // odd total of ones
          default: ;
        endcase
      end
      if (w_err) begin
        r_frame_err <= 1'b1;
        r_ext       <= 1'b0;
        r_brk       <= 1'b0;
      end else if (w_byte_valid) begin
        if (r_shift == 8'hE0)      r_ext <= 1'b1;
        else if (r_shift == 8'hF0) r_brk <= 1'b1;
        else begin
          r_ext <= 1'b0;
          r_brk <= 1'b0;
          if (!r_brk) begin
            if (w_map != 16'd0) begin
              r_kb_out    <= w_map;
              r_held      <= {r_ext, r_shift};
              r_key_event <= (w_map != r_kb_out);
            end
          end else if ({r_ext, r_shift} == r_held) begin
            r_kb_out    <= '0;
            r_held      <= '0;
            r_key_event <= (r_kb_out != 16'd0);
          end
        end
      end
    end
  end

  assign bus.kb_out    = r_kb_out;
  assign bus.key_event = r_key_event;
  assign bus.frame_err = r_frame_err;

endmodule

// File: tb/tb_ps2_keyboard.sv
module tb_ps2_keyboard;
  localparam int TO = 100;

  logic clk = 1'b0;
  logic reset = 1'b0;
  int   cyc = 0;
  int   last_fall = 0;
  int   n_checks = 0;
  int   n_pass = 0;

  typedef struct { bit is_err; logic [15:0] val; } exp_t;
  exp_t q[$];

  ps2_keyboard_if bus ();

  ps2_keyboard #(.TIMEOUT_CYCLES(TO)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0d, expected %0d", name, act, exp);
  endtask

  // Scoreboard monitor: every output pulse pops one expected entry.
  always @(negedge clk) begin
    if (reset && (bus.key_event || bus.frame_err)) begin
      if (q.size() == 0) begin
        n_checks++;
        $display("FAIL unexpected_event: got key_event=%0b frame_err=%0b kb_out=%0d, expected none",
                 bus.key_event, bus.frame_err, bus.kb_out);
      end else begin
        exp_t e;
        e = q.pop_front();
        if (e.is_err) begin
          chk("frame_err_pulse", {31'd0, bus.frame_err}, 32'd1);
        end else begin
          chk("key_event_kb_out", {16'd0, bus.kb_out}, {16'd0, e.val});
          $display("event key kb_out=%0d expected=%0d", bus.kb_out, e.val);
        end
      end
    end
  end

  task automatic ps2_bit(input logic v);
    @(negedge clk);
    bus.ps2_data = v;
    repeat (10) @(negedge clk);
    bus.ps2_clk = 1'b0;
    last_fall = cyc;
    repeat (20) @(negedge clk);
    bus.ps2_clk = 1'b1;
    repeat (10) @(negedge clk);
  endtask

  task automatic send(input logic [7:0] b, input bit bad_par = 0, input bit bad_stop = 0);
    ps2_bit(1'b0);
    for (int i = 0; i < 8; i++) ps2_bit(b[i]);
    ps2_bit((~^b) ^ bad_par);
    ps2_bit(~bad_stop);
    bus.ps2_data = 1'b1;
    repeat (10) @(negedge clk);
    $display("frame 0x%02h bad_par=%0b bad_stop=%0b kb_out=%0d", b, bad_par, bad_stop, bus.kb_out);
  endtask

  task automatic push_key(input logic [15:0] v);
    exp_t e;
    e.is_err = 0; e.val = v;
    q.push_back(e);
  endtask

  task automatic push_err();
    exp_t e;
    e.is_err = 1; e.val = 16'd0;
    q.push_back(e);
  endtask

  initial begin
    bus.ps2_clk  = 1'b1;
    bus.ps2_data = 1'b1;
    repeat (5) @(negedge clk);
    chk("reset_kb_out", {16'd0, bus.kb_out}, 32'd0);
    chk("reset_key_event", {31'd0, bus.key_event}, 32'd0);
    chk("reset_frame_err", {31'd0, bus.frame_err}, 32'd0);
    reset = 1'b1;
    repeat (5) @(negedge clk);

    // Press A, then reset in the middle of another frame.
    push_key(16'd65); send(8'h1C);
    chk("make_A", {16'd0, bus.kb_out}, 32'd65);
    ps2_bit(1'b0); ps2_bit(1'b1); ps2_bit(1'b0); ps2_bit(1'b1);
    reset = 1'b0;
    repeat (3) @(negedge clk);
    chk("midframe_reset_kb_out", {16'd0, bus.kb_out}, 32'd0);
    chk("midframe_reset_frame_err", {31'd0, bus.frame_err}, 32'd0);
    reset = 1'b1;
    repeat (5) @(negedge clk);

    // Make, typematic repeat, break.
    push_key(16'd65); send(8'h1C);
    chk("after_reset_A", {16'd0, bus.kb_out}, 32'd65);
    send(8'h1C);
    push_key(16'd0); send(8'hF0); send(8'h1C);
    chk("break_A", {16'd0, bus.kb_out}, 32'd0);

    // Extended up, B wins, break of up ignored.
    push_key(16'd131); send(8'hE0); send(8'h75);
    chk("make_up", {16'd0, bus.kb_out}, 32'd131);
    push_key(16'd66); send(8'h32);
    send(8'hE0); send(8'hF0); send(8'h75);
    chk("break_up_ignored", {16'd0, bus.kb_out}, 32'd66);

    // Framing errors leave the held key alone.
    push_err(); send(8'h1C, 1, 0);
    chk("bad_parity_kb_out", {16'd0, bus.kb_out}, 32'd66);
    push_err(); send(8'h1C, 0, 1);
    chk("bad_stop_kb_out", {16'd0, bus.kb_out}, 32'd66);

    // Unmapped codes and an IDLE glitch do nothing.
    send(8'h75); send(8'h05);
    bus.ps2_data = 1'b1;
    ps2_bit(1'b1);
    repeat (10) @(negedge clk);
    chk("unmapped_glitch_kb_out", {16'd0, bus.kb_out}, 32'd66);

    // Break B; then up with the F0 E0 prefix order on release.
    push_key(16'd0); send(8'hF0); send(8'h32);
    chk("break_B", {16'd0, bus.kb_out}, 32'd0);
    push_key(16'd131); send(8'hE0); send(8'h75);
    push_key(16'd0); send(8'hF0); send(8'hE0); send(8'h75);
    chk("break_up_swapped_prefix", {16'd0, bus.kb_out}, 32'd0);

`ifdef PS2_TIMEOUT_EN
    begin
      int t0;
      int delta;
      push_err();
      ps2_bit(1'b0); ps2_bit(1'b1); ps2_bit(1'b1); ps2_bit(1'b0);
      t0 = last_fall;
      delta = -1;
      for (int i = 0; i < 3 * TO; i++) begin
        @(negedge clk);
        if (bus.frame_err) begin
          delta = cyc - t0;
          break;
        end
      end
      // Pin fall to edge is 2-3 cycles, plus the registered output.
      n_checks++;
      if (delta >= TO + 1 && delta <= TO + 4) n_pass++;
      else $display("FAIL timeout_latency: got %0d cycles, expected %0d..%0d", delta, TO + 1, TO + 4);
      $display("timeout frame_err after %0d cycles from pin fall", delta);
      repeat (5) @(negedge clk);
    end
`endif

    push_key(16'd32); send(8'h29);
    chk("make_space", {16'd0, bus.kb_out}, 32'd32);

    repeat (20) @(negedge clk);
    chk("scoreboard_drained", q.size(), 32'd0);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

  initial begin
    #20ms;
    $display("FAIL watchdog: got timeout, expected completion");
    $fatal(1, "watchdog");
  end
endmodule
